// File: rtl/argb_bmp_pkg.sv
// argb_bmp_pkg: serializer FSM states, ARGB byte-lane indices and BMP row padding helper.
package argb_bmp_pkg;
    typedef enum logic [2:0] {IDLE, SEND_B, SEND_G, SEND_R, PAD} ser_state_t;
    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;
    // Zero bytes needed so a row of 3-byte pixels ends on a 4-byte boundary.
    function automatic int pad_bytes(input int width);
        return (4 - ((3 * width) % 4)) % 4;
    endfunction
endpackage

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: synchronous FIFO with flush; count reports occupancy 0..DEPTH.
module pixel_word_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full    = cnt_q == FULL_CNT;
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(do_push);
        rd_d  = flush ? '0 : rd_q + AW'(do_pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/argb_bmp_serializer.sv
// argb_bmp_serializer: buffers ARGB words and emits them as a row-padded 24-bit BMP byte stream.
module argb_bmp_serializer
    import argb_bmp_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] pixel_in,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_done
);
    localparam int PAD_BYTES = pad_bytes(IMG_WIDTH);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [1:0]    LAST_PAD = 2'(PAD_BYTES - 1);
    localparam logic [FW-1:0] DEPTH_CNT = FW'(FIFO_DEPTH);
    ser_state_t state_q, state_d;
    logic [23:0] hold_q, hold_d, fifo_dout;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0] pad_q, pad_d;
    logic done_q, done_d;
    logic push, pop, fifo_empty, unused_full, row_end;
    logic [FW-1:0] fifo_count;
    logic unused_alpha;
    assign unused_alpha = ^pixel_in[31:24];
    assign pixel_ready  = fifo_count < DEPTH_CNT;
    assign push         = pixel_valid && pixel_ready && !frame_start;
    pixel_word_fifo #(.DATA_W(24), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (frame_start),
        .push  (push),
        .pop   (pop),
        .din   (pixel_in[23:0]),
        .dout  (fifo_dout),
        .full  (unused_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        col_d   = col_q;
        row_d   = row_q;
        pad_d   = pad_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        row_end = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                hold_d  = fifo_dout;
                state_d = SEND_B;
            end
            SEND_B: if (byte_ready) state_d = SEND_G;
            SEND_G: if (byte_ready) state_d = SEND_R;
            SEND_R: if (byte_ready) begin
                if (col_q != LAST_COL) begin
                    col_d   = col_q + CW'(1);
                    state_d = IDLE;
                end else if (PAD_BYTES > 0) state_d = PAD;
                else row_end = 1'b1;
            end
            PAD: if (byte_ready) begin
                if (pad_q == LAST_PAD) row_end = 1'b1;
                else pad_d = pad_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
        if (row_end) begin
            col_d   = '0;
            pad_d   = '0;
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            done_d  = row_q == LAST_ROW;
            state_d = IDLE;
        end
        // A new frame discards everything in flight, including a pending pop.
        if (frame_start) begin
            state_d = IDLE;
            col_d   = '0;
            row_d   = '0;
            pad_d   = '0;
            done_d  = 1'b0;
            pop     = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pad_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pad_q   <= pad_d;
            done_q  <= done_d;
        end
    end
    assign byte_valid = state_q != IDLE;
    assign frame_done = done_q;
    assign byte_out   = (state_q == SEND_B) ? hold_q[8*LANE_B +: 8] :
                        (state_q == SEND_G) ? hold_q[8*LANE_G +: 8] :
                        (state_q == SEND_R) ? hold_q[8*LANE_R +: 8] : 8'h00;
endmodule

// File: tb/tb_argb_bmp_serializer.sv
// tb_argb_bmp_serializer: two serializer configurations (2x2 padded, 4x1 unpadded) on shared stimulus,
// checked against a word-list-to-BMP-byte model.
module tb_argb_bmp_serializer;
    logic clk = 1'b0;
    logic rst, frame_start, pixel_valid, byte_ready;
    logic [31:0] pixel_in;
    logic pr_a, bv_a, fd_a, pr_b, bv_b, fd_b;
    logic [7:0] bo_a, bo_b;
    int checks = 0;
    int failures = 0;
    logic [31:0] acc_a[$], acc_b[$];
    logic [7:0] obs_a[$], obs_b[$], exp_q[$];
    int done_a[$], done_b[$], exp_done[$];
    logic [7:0] d_got, d_exp;

    always #5 clk = ~clk;

    argb_bmp_serializer #(.IMG_WIDTH(2), .IMG_HEIGHT(2), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(pr_a), .byte_out(bo_a),
        .byte_valid(bv_a), .byte_ready(byte_ready), .frame_done(fd_a));
    argb_bmp_serializer #(.IMG_WIDTH(4), .IMG_HEIGHT(1), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_in(pixel_in),
        .pixel_valid(pixel_valid), .pixel_ready(pr_b), .byte_out(bo_b),
        .byte_valid(bv_b), .byte_ready(byte_ready), .frame_done(fd_b));

    // Inputs change just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst || frame_start) begin
            acc_a.delete(); acc_b.delete(); obs_a.delete(); obs_b.delete();
            done_a.delete(); done_b.delete();
        end else begin
            if (fd_a) done_a.push_back(obs_a.size());
            if (fd_b) done_b.push_back(obs_b.size());
            if (pixel_valid && pr_a) acc_a.push_back(pixel_in);
            if (pixel_valid && pr_b) acc_b.push_back(pixel_in);
            if (bv_a && byte_ready) obs_a.push_back(bo_a);
            if (bv_b && byte_ready) obs_b.push_back(bo_b);
        end
    end

    function automatic int exp_len(input int n, input int w);
        return 3 * n + (n / w) * ((4 - (3 * w) % 4) % 4);
    endfunction

    task automatic build_exp(input bit sel, input int w, input int h);
        int col = 0;
        int row = 0;
        int pad = (4 - (3 * w) % 4) % 4;
        int n = sel ? acc_b.size() : acc_a.size();
        logic [31:0] wd;
        exp_q.delete(); exp_done.delete();
        for (int i = 0; i < n; i++) begin
            wd = sel ? acc_b[i] : acc_a[i];
            exp_q.push_back(wd[7:0]);
            exp_q.push_back(wd[15:8]);
            exp_q.push_back(wd[23:16]);
            col = col + 1;
            if (col == w) begin
                col = 0;
                repeat (pad) exp_q.push_back(8'h00);
                row = row + 1;
                if (row == h) begin
                    row = 0;
                    exp_done.push_back(exp_q.size());
                end
            end
        end
    endtask

    task automatic diff(input bit sel, output int idx, output bit dbad);
        int n = sel ? obs_b.size() : obs_a.size();
        idx = -1;
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            d_got = sel ? obs_b[i] : obs_a[i];
            d_exp = exp_q[i];
            if (d_got !== d_exp) begin
                idx = i;
                break;
            end
        end
        if (idx < 0 && n != exp_q.size()) begin
            idx = (n < exp_q.size()) ? n : exp_q.size();
            d_got = 8'h00;
            d_exp = 8'h00;
        end
        n = sel ? done_b.size() : done_a.size();
        dbad = n != exp_done.size();
        for (int i = 0; i < n && !dbad; i++) dbad = (sel ? done_b[i] : done_a[i]) != exp_done[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int t = 0;
        while (!(pr_a && pr_b) && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 100) begin
            failures++;
            $display("FAIL send_wait ready_a=%b ready_b=%b want both 1", pr_a, pr_b);
        end
        pixel_in = w;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        byte_ready = 1'b1;
        pixel_valid = 1'b0;
        while ((obs_a.size() < exp_len(acc_a.size(), 2) || obs_b.size() < exp_len(acc_b.size(), 4)) && t < 600) begin
            tick();
            t++;
        end
        repeat (3) tick();
        checks++;
        if (t >= 600) begin
            failures++;
            $display("FAIL %s_drain got_a=%0d got_b=%0d bytes, want %0d and %0d", name,
                     obs_a.size(), obs_b.size(), exp_len(acc_a.size(), 2), exp_len(acc_b.size(), 4));
        end
    endtask

    task automatic test_reset();
        int t = 0;
        #1;
        checks++;
        if ({bv_a, fd_a, pr_a, bo_a} !== 11'b001_0000_0000) begin
            failures++;
            $display("FAIL reset_initial got v/d/r/byte=%b/%b/%b/%h want 0/0/1/00", bv_a, fd_a, pr_a, bo_a);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        byte_ready = 1'b0;
        send(32'hFF123456);
        send(32'hFF654321);
        send(32'hFF0F0F0F);
        while (!bv_a && t < 10) begin
            tick();
            t++;
        end
        checks++;
        if (bv_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_precondition byte_valid=%b want 1", bv_a);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bv_a, fd_a, pr_a, bo_a, bv_b, pr_b} !== 13'b001_0000_0000_01) begin
            failures++;
            $display("FAIL reset_async got a v/d/r/byte=%b/%b/%b/%h b v/r=%b/%b want 0/0/1/00 0/1",
                     bv_a, fd_a, pr_a, bo_a, bv_b, pr_b);
        end
        tick();
        rst = 1'b0;
        byte_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (obs_a.size() != 0 || bv_a !== 1'b0 || pr_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo_empty got bytes=%0d valid=%b ready=%b want 0/0/1", obs_a.size(), bv_a, pr_a);
        end
    endtask

    task automatic test_w2h2();
        logic [7:0] want [16] = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h00, 8'h00,
                                  8'h99, 8'h88, 8'h77, 8'hCC, 8'hBB, 8'hAA, 8'h00, 8'h00};
        int idx, bad;
        bit dbad;
        byte_ready = 1'b1;
        pulse_fs();
        send(32'hFF112233);
        send(32'hFF445566);
        send(32'hFF778899);
        send(32'hFFAABBCC);
        drain("w2h2");
        bad = -1;
        for (int i = 0; i < 16 && i < obs_a.size(); i++) if (bad < 0 && obs_a[i] !== want[i]) bad = i;
        checks++;
        if (obs_a.size() != 16 || bad >= 0) begin
            failures++;
            $display("FAIL w2h2_literal got_len=%0d first_bad=%0d want_len=16 first_bad=-1", obs_a.size(), bad);
        end
        checks++;
        if (done_a.size() != 1 || (done_a.size() == 1 && done_a[0] != 16)) begin
            failures++;
            $display("FAIL w2h2_done got_pulses=%0d want one pulse after byte 16", done_a.size());
        end
        build_exp(0, 2, 2);
        diff(0, idx, dbad);
        checks++;
        if (idx >= 0) begin
            failures++;
            $display("FAIL w2h2_model idx=%0d got=%h want=%h", idx, d_got, d_exp);
        end
    endtask

    task automatic test_w4h1();
        int idx;
        bit dbad;
        byte_ready = 1'b1;
        pulse_fs();
        send(32'h80010203);
        send(32'h40040506);
        send(32'h20070809);
        send(32'h100A0B0C);
        drain("w4h1");
        build_exp(1, 4, 1);
        diff(1, idx, dbad);
        checks++;
        if (idx >= 0 || obs_b.size() != 12) begin
            failures++;
            $display("FAIL w4h1_bytes idx=%0d got=%h want=%h got_len=%0d want_len=12", idx, d_got, d_exp, obs_b.size());
        end
        checks++;
        if (dbad || done_b.size() != 1) begin
            failures++;
            $display("FAIL w4h1_done got_pulses=%0d want 1 after byte 12", done_b.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] more [4] = '{32'hFF102030, 32'hFF405060, 32'hFF708090, 32'hFFA0B0C0};
        int t = 0;
        int idx;
        bit dbad;
        byte_ready = 1'b0;
        pulse_fs();
        byte_ready = 1'b1;
        send(32'hFF0A0B0C);
        while (!(bv_a && bo_a == 8'h0B) && t < 20) begin
            tick();
            t++;
        end
        byte_ready = 1'b0;
        checks++;
        if (t >= 20) begin
            failures++;
            $display("FAIL bp_reach_g got byte=%h valid=%b want 0b/1", bo_a, bv_a);
        end
        for (int i = 0; i < 10; i++) begin
            pixel_valid = i < 4;
            pixel_in = more[i % 4];
            tick();
            checks++;
            if (bo_a !== 8'h0B || bv_a !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got byte=%h valid=%b want 0b/1", i, bo_a, bv_a);
            end
        end
        pixel_valid = 1'b0;
        checks++;
        if (pr_a !== 1'b0) begin
            failures++;
            $display("FAIL bp_full pixel_ready=%b want 0", pr_a);
        end
        drain("bp");
        build_exp(0, 2, 2);
        diff(0, idx, dbad);
        checks++;
        if (idx >= 0 || dbad) begin
            failures++;
            $display("FAIL bp_stream idx=%0d got=%h want=%h done_bad=%b", idx, d_got, d_exp, dbad);
        end
    endtask

    task automatic test_push_pop();
        int pushed = 0;
        int t = 0;
        int idx;
        bit dbad;
        byte_ready = 1'b0;
        pulse_fs();
        for (int i = 0; i < 4; i++) send($urandom);
        byte_ready = 1'b1;
        while (pushed < 8 && t < 100) begin
            pixel_valid = !bv_a;
            pixel_in = $urandom;
            if (pixel_valid) pushed++;
            tick();
            t++;
            checks++;
            if (pr_a !== 1'b1) begin
                failures++;
                $display("FAIL pushpop_ready cycle=%0d pixel_ready=%b want 1", t, pr_a);
            end
        end
        pixel_valid = 1'b0;
        drain("pushpop");
        build_exp(0, 2, 2);
        diff(0, idx, dbad);
        checks++;
        if (idx >= 0 || dbad || acc_a.size() != 12) begin
            failures++;
            $display("FAIL pushpop_stream idx=%0d got=%h want=%h words=%0d want 12", idx, d_got, d_exp, acc_a.size());
        end
    endtask

    task automatic test_frame_start();
        byte_ready = 1'b1;
        pulse_fs();
        send(32'hFF010203);
        repeat (6) tick();
        byte_ready = 1'b0;
        send(32'hFF040506);
        send(32'hFF070809);
        send(32'hFF0A0B0C);
        pixel_in = 32'h11111111;
        pixel_valid = 1'b1;
        pulse_fs();
        pixel_valid = 1'b0;
        byte_ready = 1'b1;
        send(32'h00DDEEFF);
        drain("fs");
        checks++;
        if (obs_a.size() != 3 || obs_a[0] !== 8'hFF || obs_a[1] !== 8'hEE || obs_a[2] !== 8'hDD) begin
            failures++;
            $display("FAIL fs_bytes got_len=%0d first=%h want FF EE DD only", obs_a.size(),
                     obs_a.size() > 0 ? obs_a[0] : 8'h00);
        end
        checks++;
        if (done_a.size() != 0) begin
            failures++;
            $display("FAIL fs_no_done got_pulses=%0d want 0", done_a.size());
        end
    endtask

    task automatic test_random();
        int idx;
        bit dbad;
        byte_ready = 1'b0;
        pulse_fs();
        for (int i = 0; i < 400; i++) begin
            byte_ready = $urandom_range(0, 3) != 0;
            pixel_valid = $urandom_range(0, 1) == 1;
            pixel_in = $urandom;
            tick();
        end
        drain("rand");
        build_exp(0, 2, 2);
        diff(0, idx, dbad);
        checks++;
        if (idx >= 0 || dbad) begin
            failures++;
            $display("FAIL rand_a idx=%0d got=%h want=%h done_bad=%b", idx, d_got, d_exp, dbad);
        end
        build_exp(1, 4, 1);
        diff(1, idx, dbad);
        checks++;
        if (idx >= 0 || dbad) begin
            failures++;
            $display("FAIL rand_b idx=%0d got=%h want=%h done_bad=%b", idx, d_got, d_exp, dbad);
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        byte_ready = 1'b0;
        pixel_in = '0;
        test_reset();
        test_w2h2();
        test_w4h1();
        test_backpressure();
        test_push_pop();
        test_frame_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/argb_bmp_serializer.md
Name: argb_bmp_serializer

Overview:
- Consumer end of the brightness-filter output stream.
- Accepts 32-bit ARGB pixel words ({A,R,G,B}, alpha in [31:24]) over a valid/ready handshake and buffers them in a small FIFO.
- Emits them as a 24-bit BMP byte stream (B, G, R per pixel, alpha dropped), inserting zero bytes so each row ends on a 4-byte boundary.
- Feeds the frame writeback path and signals end of frame.

Parameters:
- IMG_WIDTH, 640, pixels per row (>=1).
- IMG_HEIGHT, 480, rows per frame (>=1).
- FIFO_DEPTH, 4, input word buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle pulse; synchronously clears FIFO, counters and FSM.
- pixel_in  in  32  ARGB word {A[31:24],R[23:16],G[15:8],B[7:0]}.
- pixel_valid  in  1  pixel_in valid.
- pixel_ready  out  1  FIFO can accept; a word transfers on an edge where valid&ready.
- byte_out  out  8  serialized byte.
- byte_valid  out  1  byte_out valid.
- byte_ready  in  1  downstream accepts; a byte transfers on an edge where valid&ready.
- frame_done  out  1  one-cycle pulse after the final byte of the frame transfers.

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM IDLE, col=0, row=0, pad counter=0.
  - Outputs during and after reset: byte_out=0, byte_valid=0, frame_done=0, pixel_ready=1.
- pixel_ready = (fifo_count < FIFO_DEPTH), derived from the registered count. No write-through bypass.
- A pop and a push on the same edge are both honoured; count is unchanged.
- FSM states: IDLE, SEND_B, SEND_G, SEND_R, PAD.
  - IDLE: if FIFO not empty, pop the head into the holding register and go to SEND_B. byte_valid=0.
  - SEND_B / SEND_G / SEND_R: byte_valid=1; byte_out = hold[7:0] / hold[15:8] / hold[23:16] respectively. Advance only on byte_ready.
  - Leaving SEND_R: col increments.
    - If col was IMG_WIDTH-1 and PAD_BYTES>0: go to PAD.
    - Else if end of row: go to row-end handling (below).
    - Else: go to IDLE.
  - PAD: byte_out=0x00, byte_valid=1. Count PAD_BYTES transfers, then do row-end handling.
  - Row-end handling: col=0, row increments. If row was IMG_HEIGHT-1: row=0, pulse frame_done for the next cycle, go to IDLE.
- PAD_BYTES = (4 - (3*IMG_WIDTH mod 4)) mod 4, a compile-time constant in 0..3.
- Latency: a word accepted at edge k is popped at edge k+1; its B byte is valid from k+1. Minimum cost is 2 cycles to first byte, then 1 byte per cycle while byte_ready=1.
- Throughput: one word per 4 cycles best case (IDLE plus 3 bytes). The FIFO absorbs upstream bursts.
- While byte_valid=1 and byte_ready=0: byte_out and byte_valid hold stable; no state change.
- frame_start has priority over all other events on its edge.
  - FIFO flushed, counters zeroed, FSM to IDLE, any in-flight byte discarded, no frame_done.
  - A word presented with valid on that edge is dropped.
- Alpha bits [31:24] are ignored entirely.
- Words beyond the frame size are not an error; the next frame begins at row 0, col 0.

Decomposition:
- Package argb_bmp_pkg holds:
  - the FSM state enum (ser_state_t);
  - byte-lane index constants for B/G/R within the ARGB word;
  - the PAD_BYTES computation function.
- Sub-module pixel_word_fifo: parameterized synchronous FIFO (DATA_W=32, DEPTH).
  - Ports: push, pop, din, dout, full, empty, count, flush.
  - Same clk/rst convention.
- Top level contains the FSM, col/row/pad counters and output muxing.

Test Plan:
- Reset check: assert rst mid-frame with byte_valid=1 -> byte_valid=0, frame_done=0, pixel_ready=1 immediately (asynchronously), FIFO empty after release.
- W=2, H=2, byte_ready=1: send 0xFF112233, 0xFF445566, 0xFF778899, 0xFFAABBCC.
  - Expected bytes: 33 22 11 66 55 44 00 00 99 88 77 CC BB AA 00 00.
  - frame_done pulses once, one cycle after the last 00 transfers.
- W=4, H=1: four words -> 12 bytes, no pad bytes; frame_done after the 12th byte.
- Backpressure: hold byte_ready=0 for 10 cycles during SEND_G of 0xFF0A0B0C.
  - byte_out stays 0x0B with byte_valid=1 throughout.
  - FIFO fills to FIFO_DEPTH and pixel_ready drops to 0.
  - On release, bytes resume 0B, 0A, then the next word.
- Simultaneous push/pop with FIFO at DEPTH-1: pixel_ready stays 1 and count is unchanged; no word is lost or duplicated.
- frame_start issued mid-row with 2 words queued: the next accepted word 0x00DDEEFF emits FF EE DD as row 0, col 0; no stale bytes; frame_done is not asserted.
